// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, 2-flop row sync, press/release debounce, one valid pulse per key.
// Latency: 2 + scan slot (<=4*SCAN_DIV) + DEBOUNCE_CNT cycles to key_valid; no backpressure, pulse is fire-and-forget.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] shift_col,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    // Counter value whose increment lands on DEBOUNCE_CNT-1; together with the
    // sample that caused entry this gives DEBOUNCE_CNT stable samples.
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 2);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       rst_sync;
    logic             rst_n;
    logic [3:0]       row_meta;
    logic [3:0]       row_s;
    logic [3:0]       row_cap;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt;

    function automatic logic one_low(input logic [3:0] r);
        return (r == 4'b1110) || (r == 4'b1101) || (r == 4'b1011) || (r == 4'b0111);
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        case (v)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] key_code(input logic [3:0] r, input logic [3:0] c);
        logic [3:0] code;
        code = 4'h0;
        case ({low_idx(r), low_idx(c)})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_s    <= 4'hF;
        end else begin
            row_meta <= row;
            row_s    <= row_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            div_cnt   <= '0;
            deb_cnt   <= '0;
            row_cap   <= 4'hF;
            shift_col <= 4'b1110;
            key_value <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (one_low(row_s)) begin
                            row_cap <= row_s;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            shift_col <= {shift_col[2:0], shift_col[3]};
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (row_s != row_cap) begin
                        div_cnt <= '0;
                        state   <= SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_valid <= 1'b1;
                        key_value <= key_code(row_cap, shift_col);
                        key_held  <= 1'b1;
                        state     <= PRESSED;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                PRESSED: begin
                    // Rolling onto another key while held is deliberately ignored.
                    if (row_s == 4'hF) begin
                        deb_cnt <= '0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (row_s != 4'hF) begin
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_held  <= 1'b0;
                        div_cnt   <= '0;
                        shift_col <= {shift_col[2:0], shift_col[3]};
                        state     <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8 and a behavioural keypad matrix.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] row;
    logic [3:0] shift_col;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = 16'h0000;   // bit r*4+c = key at row r, column c is down
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          cyc = 0;
    int          last_pulse_cyc = 0;
    logic [3:0]  last_code = 4'h0;

    keypad_scanner #(
        .SCAN_DIV    (4),
        .DEBOUNCE_CNT(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .shift_col (shift_col),
        .key_value (key_value),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !shift_col[c]) row[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (key_valid) begin
            pulses         <= pulses + 1;
            last_code      <= key_value;
            last_pulse_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic release_keys(input string tag);
        int n;
        keys = 16'h0000;
        n = 0;
        while (key_held && n < 30) begin
            step(1);
            n++;
        end
        check(tag, key_held, 1'b0);
        step(4);
    endtask

    task automatic press_code(input string tag, input int idx, input logic [3:0] code);
        int p0;
        p0   = pulses;
        keys = 16'(1) << idx;
        step(40);
        check({tag, "_count"}, 16'(pulses - p0), 16'd1);
        check({tag, "_code"}, last_code, code);
        check({tag, "_value"}, key_value, code);
        check({tag, "_held"}, key_held, 1'b1);
        release_keys({tag, "_release"});
    endtask

    initial begin
        int n;
        int p0;
        int stop;
        logic [3:0] s;

        // Reset and idle scanning
        reset = 1'b0;
        step(5);
        check("rst_col", shift_col, 4'hE);
        check("rst_value", key_value, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        reset = 1'b1;
        n = 0;
        while (shift_col == 4'hE && n < 20) begin
            step(1);
            n++;
        end
        check("idle_col1", shift_col, 4'hD);
        step(4);
        check("idle_col2", shift_col, 4'hB);
        step(4);
        check("idle_col3", shift_col, 4'h7);
        step(4);
        check("idle_wrap", shift_col, 4'hE);
        p0 = pulses;
        step(100);
        check("idle_novalid", 16'(pulses - p0), 16'd0);

        // Single press r1,c1 -> 5
        p0   = pulses;
        keys = 16'h0020;
        step(60);
        check("p5_count", 16'(pulses - p0), 16'd1);
        check("p5_code", last_code, 4'h5);
        check("p5_held", key_held, 1'b1);
        keys = 16'h0000;
        n = 0;
        while (key_held && n < 30) begin
            step(1);
            n++;
        end
        check("p5_rel_latency", 16'(n), 16'd10);
        check("p5_resume_col", shift_col, 4'hB);
        step(4);

        // Bouncing r2,c3 -> C
        p0 = pulses;
        for (int i = 0; i < 8; i++) begin
            keys = (i % 2 == 0) ? 16'h0800 : 16'h0000;
            step(3);
        end
        check("bnc_during", 16'(pulses - p0), 16'd0);
        stop = cyc;
        keys = 16'h0800;
        step(40);
        check("bnc_count", 16'(pulses - p0), 16'd1);
        check("bnc_code", last_code, 4'hC);
        check("bnc_stable", 16'(last_pulse_cyc - stop >= 8), 16'd1);
        release_keys("bnc_release");

        // Two rows on one column: no report, scan keeps moving
        p0   = pulses;
        keys = 16'h0202;
        step(60);
        check("ghost_count", 16'(pulses - p0), 16'd0);
        check("ghost_held", key_held, 1'b0);
        s = shift_col;
        step(4);
        check("ghost_scanning", 16'(shift_col != s), 16'd1);
        keys = 16'h0000;
        step(10);

        // Short glitch on r3,c2 is not reported
        p0   = pulses;
        keys = 16'h4000;
        step(5);
        keys = 16'h0000;
        step(30);
        check("glitch_count", 16'(pulses - p0), 16'd0);
        check("glitch_held", key_held, 1'b0);

        press_code("key_f", 14, 4'hF);
        press_code("key_e", 12, 4'hE);
        press_code("key_d", 15, 4'hD);

        // Reset while r0,c0 is in PRESSED
        p0   = pulses;
        keys = 16'h0001;
        n = 0;
        while (pulses == p0 && n < 40) begin
            step(1);
            n++;
        end
        check("mr_press", 16'(pulses - p0), 16'd1);
        step(2);
        check("mr_held_before", key_held, 1'b1);
        reset = 1'b0;
        #1;
        check("mr_held_reset", key_held, 1'b0);
        check("mr_col_reset", shift_col, 4'hE);
        p0 = pulses;
        step(3);
        check("mr_no_valid", 16'(pulses - p0), 16'd0);
        reset = 1'b1;
        n = 0;
        while (pulses == p0 && n < 26) begin
            step(1);
            n++;
        end
        check("mr_repress", 16'(pulses - p0), 16'd1);
        check("mr_code", last_code, 4'h1);
        release_keys("mr_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
